// File: rtl/output_buffer.sv
// Result buffer behind the accumulator: captures addressed 32-bit results with
// per-entry valid bits and drains entries 0..len-1 over a valid/ready stream.
module output_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              drain_start,
    input  logic [ADDR_W-1:0] drain_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_written,
    output logic              busy,
    output logic              done,
    output logic              overwrite_err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [DEPTH-1:0]    valid_r;
    logic [DEPTH-1:0]    valid_nxt_s;
    logic [ADDR_W:0]     idx_r;
    logic [ADDR_W:0]     idx_nxt_s;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W:0]     len_nxt_s;

    logic                xfer_s;
    logic                last_s;
    logic                load_s;
    logic [ADDR_W-1:0]   load_addr_s;
    logic [DATA_W-1:0]   load_data_s;
    logic                load_written_s;

    logic                out_valid_r;
    logic                out_valid_nxt_s;
    logic [DATA_W-1:0]   out_data_r;
    logic [DATA_W-1:0]   out_data_nxt_s;
    logic [ADDR_W-1:0]   out_addr_r;
    logic [ADDR_W-1:0]   out_addr_nxt_s;
    logic                out_written_r;
    logic                out_written_nxt_s;
    logic                busy_r;
    logic                busy_nxt_s;
    logic                done_r;
    logic                done_nxt_s;
    logic                overwrite_err_r;
    logic                overwrite_err_nxt_s;

    assign xfer_s = out_valid_r && out_ready;
    assign last_s = xfer_s && (idx_r == (len_r - IDX_ONE));

    // Next-state logic for the drain FSM and its index/length counters
    always_comb begin
        state_nxt_s = state_r;
        len_nxt_s   = len_r;
        idx_nxt_s   = idx_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (drain_start) begin
                    state_nxt_s = ST_DRAIN;
                    len_nxt_s   = (drain_len == '0) ? LEN_FULL : {1'b0, drain_len};
                    idx_nxt_s   = '0;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (last_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (xfer_s) begin
                    idx_nxt_s = idx_r + IDX_ONE;
                    load_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Word to present next; a same-cycle write to that entry is forwarded
    always_comb begin
        load_addr_s = idx_nxt_s[ADDR_W-1:0];
        if (wr_en && (wr_addr == load_addr_s)) begin
            load_data_s    = wr_data;
            load_written_s = 1'b1;
        end else if (valid_r[load_addr_s]) begin
            load_data_s    = mem_r[load_addr_s];
            load_written_s = 1'b1;
        end else begin
            load_data_s    = '0;
            load_written_s = 1'b0;
        end
    end

    // Stream output next values; the presented word only changes on a load
    always_comb begin
        out_valid_nxt_s   = out_valid_r;
        out_data_nxt_s    = out_data_r;
        out_addr_nxt_s    = out_addr_r;
        out_written_nxt_s = out_written_r;
        done_nxt_s        = last_s;
        busy_nxt_s        = (state_nxt_s == ST_DRAIN);
        if (load_s) begin
            out_valid_nxt_s   = 1'b1;
            out_data_nxt_s    = load_data_s;
            out_addr_nxt_s    = load_addr_s;
            out_written_nxt_s = load_written_s;
        end else if (last_s) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // Valid-bit bookkeeping; a write in the transfer cycle keeps the entry valid
    always_comb begin
        valid_nxt_s         = valid_r;
        overwrite_err_nxt_s = overwrite_err_r | (wr_en & valid_r[wr_addr]);
        if (xfer_s) begin
            valid_nxt_s[out_addr_r] = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
        if (wr_en) begin
            valid_nxt_s[wr_addr] = 1'b1;
        end else begin
            valid_nxt_s = valid_nxt_s;
        end
    end

    // Result storage; contents are qualified by valid_r so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Control, status and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            valid_r         <= '0;
            idx_r           <= '0;
            len_r           <= '0;
            out_valid_r     <= 1'b0;
            out_data_r      <= '0;
            out_addr_r      <= '0;
            out_written_r   <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            overwrite_err_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            valid_r         <= valid_nxt_s;
            idx_r           <= idx_nxt_s;
            len_r           <= len_nxt_s;
            out_valid_r     <= out_valid_nxt_s;
            out_data_r      <= out_data_nxt_s;
            out_addr_r      <= out_addr_nxt_s;
            out_written_r   <= out_written_nxt_s;
            busy_r          <= busy_nxt_s;
            done_r          <= done_nxt_s;
            overwrite_err_r <= overwrite_err_nxt_s;
        end
    end

    assign out_valid     = out_valid_r;
    assign out_data      = out_data_r;
    assign out_addr      = out_addr_r;
    assign out_written   = out_written_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign overwrite_err = overwrite_err_r;

endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: a transaction-level model of the entry
// array predicts each drained beat; a negedge monitor pops and compares.
module tb_output_buffer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        drain_start;
    logic [3:0]  drain_len;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_addr;
    logic        out_written;
    logic        busy;
    logic        done;
    logic        overwrite_err;

    output_buffer #(.DEPTH(16), .ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .drain_start(drain_start), .drain_len(drain_len), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_written(out_written), .busy(busy), .done(done), .overwrite_err(overwrite_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        logic        w;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] m_mem [16];
    logic [15:0] m_valid = 16'h0;
    logic        m_err   = 1'b0;
    int          tests   = 0;
    int          fails   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Monitor: compares every transfer, stall stability and the done pulse
    logic        exp_done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] sv_data;
    logic [3:0]  sv_addr;
    logic        sv_wr;
    always @(negedge clk) begin
        if (rst) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("done", done, exp_done);
            if (exp_done) chk("busy_at_done", busy, 1'b0);
            exp_done = 1'b0;
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, sv_data);
                chk("stall_addr", out_addr, sv_addr);
                chk("stall_written", out_written, sv_wr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_addr), 32'hFFFF_FFFF);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_addr", out_addr, b.a);
                    chk("beat_data", out_data, b.d);
                    chk("beat_written", out_written, b.w);
                    exp_done = b.last;
                end
            end
            prev_stall = out_valid && !out_ready;
            sv_data    = out_data;
            sv_addr    = out_addr;
            sv_wr      = out_written;
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        if (m_valid[a]) m_err = 1'b1;
        m_mem[a]   = d;
        m_valid[a] = 1'b1;
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.a    = 4'(i);
            b.d    = m_valid[i] ? m_mem[i] : 32'h0;
            b.w    = m_valid[i];
            b.last = (i == n - 1);
            exp_q.push_back(b);
            m_valid[i] = 1'b0;
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic drain(input int len_in, input int mode);
        int n;
        int k;
        n = (len_in == 0) ? 16 : len_in;
        k = 0;
        push_exp(n);
        drain_start = 1'b1; drain_len = 4'(len_in); out_ready = 1'b0;
        @(posedge clk); #1;
        drain_start = 1'b0;
        while (exp_q.size() > 0 && k < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (k == 0) begin
                @(negedge clk);
                chk("busy_in_drain", busy, 1'b1);
            end
            @(posedge clk); #1;
            k++;
        end
        out_ready = 1'b0;
        chk("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_err();
        @(negedge clk);
        chk("overwrite_err", overwrite_err, m_err);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_valid = 16'h0;
        m_err   = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 32'h0;
        drain_start = 1'b0; drain_len = 4'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_addr", out_addr, 4'h0);
        chk("rst_out_written", out_written, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overwrite_err", overwrite_err, 1'b0);
        @(posedge clk); #1;

        // Basic four-entry drain, then the same range must read back empty
        wr(0, 32'h3F800000); wr(1, 32'h40000000); wr(2, 32'h40400000); wr(3, 32'h40800000);
        check_err();
        drain(4, 0);
        drain(4, 0);

        // Back-pressure pattern
        wr(0, 32'h3F800000); wr(1, 32'h40000000); wr(2, 32'h40400000); wr(3, 32'h40800000);
        drain(4, 1);

        // Full-depth drain with a single written entry
        wr(5, 32'h41200000);
        drain(0, 0);

        // Overwrite flag, sticky across a drain
        wr(2, 32'h40000000); wr(2, 32'hC0000000);
        check_err();
        drain(3, 2);
        check_err();

        // Rewrite of the entry stalled on: presented word holds, entry stays valid
        do_reset();
        wr(0, 32'h3F800000); wr(1, 32'h40000000); wr(2, 32'h40400000);
        push_exp(3);
        m_err = 1'b1;
        drain_start = 1'b1; drain_len = 4'd3; out_ready = 1'b0;
        @(posedge clk); #1;
        drain_start = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h42C80000;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_rewrite_data", out_data, 32'h40000000);
        chk("stall_rewrite_addr", out_addr, 4'd1);
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall_rewrite_left", exp_q.size(), 0);
        m_mem[1] = 32'h42C80000; m_valid[1] = 1'b1;
        check_err();
        drain(3, 0);

        // Reset in the middle of a drain
        do_reset();
        wr(0, 32'h3F800000); wr(1, 32'h40000000); wr(2, 32'h40400000); wr(3, 32'h40800000);
        push_exp(4);
        drain_start = 1'b1; drain_len = 4'd4; out_ready = 1'b0;
        @(posedge clk); #1;
        drain_start = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("mid_valid", out_valid, 1'b1);
        chk("mid_addr", out_addr, 4'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_valid = 16'h0; m_err = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        @(posedge clk); #1;
        drain(4, 0);

        // Randomized writes and drains against the model
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(0, 6);
            for (int j = 0; j < nw; j++) wr($urandom_range(0, 15), $urandom);
            check_err();
            drain($urandom_range(0, 15), 2);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
- Result buffer directly downstream of the accumulator stage.
- Captures 32-bit results written with an address and enable, and holds them in a DEPTH-entry register file with per-entry valid bits.
- On command, drains a contiguous range, starting at entry 0, to the host/memory side over a valid/ready stream.
- Reports busy, done, and a sticky overwrite flag.

Parameters:
- DEPTH, 16, number of entries; power of two.
- ADDR_W, 4, address width; equals log2(DEPTH).
- DATA_W, 32, result word width (bfp32).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write strobe from accumulator (output_buffer_enable).
- wr_addr  in  ADDR_W  write address (output_buffer_addr).
- wr_data  in  DATA_W  result word (output_data).
- drain_start  in  1  one-cycle pulse; starts a drain (accepted in IDLE only).
- drain_len  in  ADDR_W  number of entries to drain; 0 means DEPTH.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_W  streamed word.
- out_addr  out  ADDR_W  entry index of out_data.
- out_written  out  1  entry held a valid write when it was read.
- busy  out  1  high in DRAIN state.
- done  out  1  one-cycle pulse after the last transfer.
- overwrite_err  out  1  sticky; set when a write hits an entry whose valid bit is already set.

Behaviour:
- Reset:
  - Synchronous, active-high; single clock domain clk; reset is synchronous and active-high.
  - All valid bits, out_valid, out_data, out_addr, out_written, busy, done and overwrite_err clear to 0; FSM goes to IDLE.
  - Memory contents are don't-care, but reads of entries with valid bit clear return 0.
  - Reset mid-drain aborts the drain immediately; no done pulse.
- Writes:
  - Accepted every cycle in any state.
  - mem[wr_addr] <= wr_data; valid[wr_addr] <= 1.
  - If valid[wr_addr] was already 1, overwrite_err <= 1. It stays set until rst.
- FSM states: IDLE, DRAIN.
  - IDLE -> DRAIN when drain_start=1.
    - Latch len = (drain_len==0 ? DEPTH : drain_len); idx = 0.
    - Next cycle: out_valid=1, out_addr=0, and out_data/out_written loaded from entry 0.
    - Latency from drain_start to out_valid is 1 cycle.
  - drain_start while in DRAIN is ignored.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_addr and out_written hold stable, even if that entry is rewritten.
  - On a transfer of entry i:
    - valid[i] <= 0, unless wr_en && wr_addr==i in the same cycle; the write wins and valid stays 1.
    - If i < len-1, entry i+1 is presented the next cycle with no bubble.
- Presented word:
  - out_data = valid ? mem : 0; out_written = valid.
  - Bypass: if wr_en && wr_addr equals the index being loaded in that cycle, load wr_data and set out_written=1.
- Termination:
  - On transfer of entry len-1: out_valid <= 0, done <= 1 for one cycle, FSM -> IDLE, busy <= 0.
  - busy is high from the cycle after drain_start until the cycle done is asserted.
  - A new drain_start is accepted in the same cycle done is high.
- Counters: idx is ADDR_W+1 bits wide, so the len=DEPTH case needs no wrap; idx never exceeds len.

Test Plan:
- Reset, then write entries 0..3 = 0x3F800000, 0x40000000, 0x40400000, 0x40800000; drain_start with drain_len=4, out_ready=1 -> four consecutive beats, out_addr 0..3 with matching data and out_written=1; done pulses the cycle after beat 3; all four valid bits end cleared.
- Same writes, out_ready toggling 1,0,0,1,... -> out_data/out_addr stay stable across stalls; exactly 4 transfers; no duplicates.
- Write only entry 5 = 0x41200000; drain_len=0 -> 16 beats; beat 5 carries 0x41200000 with out_written=1; all other beats carry 0 with out_written=0; done after beat 15.
- Write entry 2 twice before draining -> overwrite_err=1, remains 1 after the drain; second value 0x C0000000 is streamed.
- During a drain stalled on entry 1 (out_ready=0), write entry 1 = 0x42C80000 -> presented word is unchanged; after the transfer, valid[1] stays 1; a second drain returns 0x42C80000.
- Assert rst while out_valid=1 at entry 2 -> next cycle out_valid=0, busy=0, no done pulse; an immediate drain returns zeros with out_written=0.
